// File: rtl/regfile_pkg.sv
// Shared constants, word type and reset-image helper for the 2R1W register file.
// Optional build macro REGFILE_BYPASS_EN forwards same-edge writes to the read ports.
package regfile_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 2;
  localparam int DEF_INIT_BASE = 4;

  typedef logic [DEF_WIDTH-1:0] word_t;

  // Reset value of entry i; callers cast the result down to their own WIDTH.
  function automatic logic [63:0] init_val(input int unsigned base,
                                           input int unsigned i,
                                           input int unsigned width);
    logic [63:0] v;
    v = 64'(base) + 64'(i);
    if (width < 64) v = v & ((64'd1 << width) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: samples data and pending bit for its address.
// With REGFILE_BYPASS_EN defined, a same-edge write to the read address is forwarded.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AW-1:0]               rd_addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            pend_q,
  input  logic [DEPTH-1:0]            pend_d,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        pend
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             pbit_d, pbit_q;

  always_comb begin
    data_d = mem[rd_addr];
    pbit_d = pend_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarded pending is the post-edge bit, so a same-address reserve still shows.
    if (wr_en && (wr_addr == rd_addr)) begin
      data_d = wr_data;
      pbit_d = pend_d[rd_addr];
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{wr_en, wr_addr, wr_data, pend_d};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pbit_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pbit_q <= pbit_d;
    end
  end

  assign rd_data = data_q;
  assign pend    = pbit_q;

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, one write and two registered read ports, with a
// per-entry pending scoreboard. Build macro REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  INIT_BASE = DEF_INIT_BASE,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             pend1,
  output logic             pend2,
  output logic             any_pend
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            pend_q, pend_d;
  logic                        any_pend_q;

  // Reserve is applied after the write clear so it wins on a shared address.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_en) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (rsv_en) pend_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= WIDTH'(init_val(INIT_BASE, i, WIDTH));
      pend_q     <= '0;
      any_pend_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      any_pend_q <= |pend_d;
    end
  end

  logic [1:0][AW-1:0]    rd_addr;
  logic [1:0][WIDTH-1:0] rd_data;
  logic [1:0]            rd_pend;

  assign rd_addr = {rd_addr2, rd_addr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (rd_addr[p]),
      .mem     (mem_q),
      .pend_q  (pend_q),
      .pend_d  (pend_d),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p]),
      .pend    (rd_pend[p])
    );
  end

  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];
  assign pend1    = rd_pend[0];
  assign pend2    = rd_pend[1];
  assign any_pend = any_pend_q;

endmodule
